mux4to1_rr: RTL and testbench

- Four-channel round-robin stream multiplexer with valid/ready handshakes on every channel.
- Merges four independent producers onto one output stream. Each output beat is tagged with its source channel on out_sel, so a 1:4 demultiplexer at the far end can steer it back to the matching sink.
- Output is registered; optional burst hold keeps the grant on one channel for up to BURST consecutive beats.

---
 rtl/mux4to1_rr.sv | 106 ++++++++++
 tb/tb_mux4to1_rr.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4to1_rr.sv
// Four-channel round-robin stream multiplexer with optional burst hold.
// Beats from channels 0..3 are merged onto one registered output stream.
// Each beat carries its source channel on out_sel.
//
// Handshake semantics (all channels and the output): a beat transfers on a
// rising edge where valid and ready are both 1. A producer keeps valid and
// data stable until that edge. Ready may depend combinationally on valid,
// but valid never depends on ready. out_valid only drops after a transfer.
module mux4to1_rr #(
  parameter int W     = 8,
  parameter int BURST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  // beat_cnt must hold BURST itself; it saturates there and never wraps.
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  logic [1:0]    last_sel;
  logic [CW-1:0] beat_cnt;
  logic          load_en;
  logic          any_valid;
  logic          hold;
  logic [1:0]    rr_grant;
  logic [1:0]    grant;
  logic [W-1:0]  grant_data;

  assign load_en   = !out_valid || out_ready;
  assign any_valid = |in_valid;

  // The channel that owns the grant keeps it while its burst budget lasts.
  assign hold  = (beat_cnt != '0) && in_valid[last_sel] && (beat_cnt < BURST_C);
  assign grant = hold ? last_sel : rr_grant;

  // Round-robin search: first valid channel after last_sel, last_sel itself last.
  always_comb begin : rr_pick
    logic [1:0] idx;
    logic       found;
    idx      = '0;
    found    = 1'b0;
    rr_grant = last_sel;
    for (int k = 1; k <= 4; k++) begin
      idx = last_sel + 2'(k);
      if (!found && in_valid[idx]) begin
        rr_grant = idx;
        found    = 1'b1;
      end
    end
  end

  // Data of the granted channel.
  always_comb begin
    case (grant)
      2'd0:    grant_data = in_data0;
      2'd1:    grant_data = in_data1;
      2'd2:    grant_data = in_data2;
      default: grant_data = in_data3;
    endcase
  end

  // Consume the granted beat this cycle; nothing is consumed during reset.
  always_comb begin
    in_ready = 4'b0000;
    if (!rst && load_en && any_valid) begin
      in_ready = 4'b0001 << grant;
    end
  end

  // Output register and arbitration state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      last_sel  <= 2'd3;
      beat_cnt  <= '0;
    end else if (load_en) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
        last_sel  <= grant;
        beat_cnt  <= hold ? beat_cnt + 1'b1 : CW'(1);
      end else begin
        if (out_ready) begin
          out_valid <= 1'b0;
        end
        // An idle slot ends any burst in progress.
        beat_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux4to1_rr.sv
// Bench for mux4to1_rr: two instances (BURST=1 and BURST=2) with separate
// stimulus, a behavioural arbitration model, and a beat scoreboard.
module tb_mux4to1_rr;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid  [2];
  logic [W-1:0] in_data   [2][4];
  logic         out_ready [2];
  logic [3:0]   in_ready  [2];
  logic         out_valid [2];
  logic [W-1:0] out_data  [2];
  logic [1:0]   out_sel   [2];

  int checks = 0;
  int errors = 0;

  // Behavioural model state per instance.
  logic         m_valid [2];
  logic [W-1:0] m_data  [2];
  int           m_sel   [2];
  int           m_last  [2];
  int           m_cnt   [2];
  logic [3:0]   taken   [2];

  // Expected beats {sel, data} in order, and observed output beats.
  logic [W+1:0] exp_q0[$];
  logic [W+1:0] exp_q1[$];
  logic [W+1:0] log0[$];
  logic [W+1:0] log1[$];

  int fair_sel  [6] = '{0, 1, 2, 3, 0, 1};
  int fair_dat  [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
  int burst_sel [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int drop_sel  [7] = '{0, 0, 1, 2, 2, 3, 3};

  mux4to1_rr #(.W(W), .BURST(1)) dut_b1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]),
    .in_data0(in_data[0][0]), .in_data1(in_data[0][1]),
    .in_data2(in_data[0][2]), .in_data3(in_data[0][3]),
    .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_sel(out_sel[0]),
    .out_ready(out_ready[0])
  );

  mux4to1_rr #(.W(W), .BURST(2)) dut_b2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]),
    .in_data0(in_data[1][0]), .in_data1(in_data[1][1]),
    .in_data2(in_data[1][2]), .in_data3(in_data[1][3]),
    .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_sel(out_sel[1]),
    .out_ready(out_ready[1])
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  function automatic int burst_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic logic [W+1:0] log_at(input int i, input int k);
    if (i == 0) return (k < log0.size()) ? log0[k] : '1;
    return (k < log1.size()) ? log1[k] : '1;
  endfunction

  function automatic int log_size(input int i);
    return (i == 0) ? log0.size() : log1.size();
  endfunction

  // Model one cycle of instance i: compare, then advance to the post-edge state.
  task automatic monitor_inst(input int i);
    logic [3:0]   iv;
    logic [3:0]   er;
    logic         load;
    logic [W+1:0] beat;
    logic [W+1:0] want;
    int           g;
    logic         hit;
    iv = in_valid[i];
    er = 4'b0000;
    if (rst) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
      m_sel[i]   = 0;
      m_last[i]  = 3;
      m_cnt[i]   = 0;
      if (i == 0) exp_q0.delete(); else exp_q1.delete();
    end
    check("out_valid", i, 32'(out_valid[i]), 32'(m_valid[i]));
    check("out_data", i, 32'(out_data[i]), 32'(m_data[i]));
    check("out_sel", i, 32'(out_sel[i]), 32'(m_sel[i]));
    if (!rst) begin
      // Scoreboard: every output transfer must be the oldest granted beat.
      if (out_valid[i] && out_ready[i]) begin
        beat = {out_sel[i], out_data[i]};
        if (i == 0) log0.push_back(beat); else log1.push_back(beat);
        if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra inst%0d got %0h expected none", i, beat);
        end else begin
          want = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check("sb_beat", i, 32'(beat), 32'(want));
        end
      end
      load = !m_valid[i] || out_ready[i];
      if (load && iv != 4'b0000) begin
        if (m_cnt[i] > 0 && m_cnt[i] < burst_of(i) && iv[m_last[i]]) begin
          g = m_last[i];
          m_cnt[i] = m_cnt[i] + 1;
        end else begin
          g = m_last[i];
          hit = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            if (!hit && iv[(m_last[i] + k) % 4]) begin
              g = (m_last[i] + k) % 4;
              hit = 1'b1;
            end
          end
          m_last[i] = g;
          m_cnt[i]  = 1;
        end
        er[g]      = 1'b1;
        m_valid[i] = 1'b1;
        m_data[i]  = in_data[i][g];
        m_sel[i]   = g;
        if (i == 0) exp_q0.push_back({2'(g), in_data[i][g]});
        else        exp_q1.push_back({2'(g), in_data[i][g]});
      end else if (load) begin
        if (out_ready[i]) m_valid[i] = 1'b0;
        m_cnt[i] = 0;
      end
    end
    check("in_ready", i, 32'(in_ready[i]), 32'(er));
    taken[i] = er;
  endtask

  // Compare process on the inactive edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) monitor_inst(i);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int i);
    in_valid[i] = 4'b1111;
    for (int ch = 0; ch < 4; ch++) in_data[i][ch] = W'(8'h10 + ch);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic release_reset();
    rst = 1'b0;
    log0.delete();
    log1.delete();
  endtask

  task automatic random_drive(input int dens);
    for (int i = 0; i < 2; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (!(in_valid[i][ch] && !taken[i][ch])) begin
          in_valid[i][ch] = ($urandom_range(0, 99) < dens);
          in_data[i][ch]  = W'($urandom);
        end
      end
      out_ready[i] = ($urandom_range(0, 9) < 7);
    end
  endtask

  initial begin
    logic [W+1:0] e;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 4'b0000;
      out_ready[i] = 1'b1;
      taken[i]     = 4'b0000;
      for (int ch = 0; ch < 4; ch++) in_data[i][ch] = '0;
    end
    tick();

    // Reset with all inputs active, then fairness / burst sequences.
    set_all(0);
    set_all(1);
    tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", i, 32'(in_ready[i]), 32'h0);
      check("rst_out_valid", i, 32'(out_valid[i]), 32'h0);
      check("rst_out_sel", i, 32'(out_sel[i]), 32'h0);
      check("rst_out_data", i, 32'(out_data[i]), 32'h0);
    end
    release_reset();
    #1;
    check("first_grant", 0, 32'(in_ready[0]), 32'h1);
    check("first_grant", 1, 32'(in_ready[1]), 32'h1);
    repeat (10) tick();
    check("fair_count", 0, 32'(log_size(0)), 32'd9);
    check("burst_count", 1, 32'(log_size(1)), 32'd9);
    for (int k = 0; k < 6; k++) begin
      e = log_at(0, k);
      check("fair_sel", 0, 32'(e[W+1:W]), 32'(fair_sel[k]));
      check("fair_data", 0, 32'(e[W-1:0]), 32'(fair_dat[k]));
    end
    for (int k = 0; k < 9; k++) begin
      e = log_at(1, k);
      check("burst_sel", 1, 32'(e[W+1:W]), 32'(burst_sel[k]));
    end

    // Reset mid-burst: output shows first channel 2 beat of BURST=2 instance.
    do_reset();
    set_all(1);
    release_reset();
    repeat (5) tick();
    check("pre_rst_sel", 1, 32'(out_sel[1]), 32'd2);
    rst = 1'b1;
    #1;
    check("async_out_valid", 1, 32'(out_valid[1]), 32'h0);
    check("async_out_sel", 1, 32'(out_sel[1]), 32'h0);
    check("async_out_data", 1, 32'(out_data[1]), 32'h0);
    check("async_in_ready", 1, 32'(in_ready[1]), 32'h0);
    tick();
    release_reset();
    #1;
    check("post_rst_grant", 1, 32'(in_ready[1]), 32'h1);

    // Single beat on channel 2.
    do_reset();
    in_valid[0] = 4'b0000;
    in_valid[1] = 4'b0000;
    release_reset();
    tick();
    in_valid[0]    = 4'b0100;
    in_data[0][2]  = 8'hA5;
    out_ready[0]   = 1'b1;
    #1;
    check("single_ready", 0, 32'(in_ready[0]), 32'h4);
    tick();
    in_valid[0] = 4'b0000;
    #1;
    check("single_valid", 0, 32'(out_valid[0]), 32'h1);
    check("single_sel", 0, 32'(out_sel[0]), 32'd2);
    check("single_data", 0, 32'(out_data[0]), 32'hA5);
    tick();
    check("single_drop", 0, 32'(out_valid[0]), 32'h0);

    // Burst hold with channel 1 leaving after its first beat.
    do_reset();
    set_all(1);
    out_ready[1] = 1'b1;
    release_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 2) in_valid[1][1] = 1'b0;
    end
    for (int k = 0; k < 7; k++) begin
      e = log_at(1, k);
      check("drop_sel", 1, 32'(e[W+1:W]), 32'(drop_sel[k]));
    end

    // Backpressure on a channel 1 beat, then no-bubble reload.
    do_reset();
    in_valid[1]   = 4'b0000;
    in_valid[0]   = 4'b0010;
    in_data[0][1] = 8'h3C;
    out_ready[0]  = 1'b1;
    release_reset();
    tick();
    in_valid[0]   = 4'b0001;
    in_data[0][0] = 8'h77;
    out_ready[0]  = 1'b0;
    for (int r = 0; r < 3; r++) begin
      if (r != 0) tick();
      #1;
      check("bp_valid", 0, 32'(out_valid[0]), 32'h1);
      check("bp_sel", 0, 32'(out_sel[0]), 32'd1);
      check("bp_data", 0, 32'(out_data[0]), 32'h3C);
      check("bp_ready", 0, 32'(in_ready[0]), 32'h0);
    end
    tick();
    out_ready[0] = 1'b1;
    #1;
    check("bp_reload_ready", 0, 32'(in_ready[0]), 32'h1);
    tick();
    in_valid[0] = 4'b0000;
    #1;
    check("bp_reload_valid", 0, 32'(out_valid[0]), 32'h1);
    check("bp_reload_sel", 0, 32'(out_sel[0]), 32'd0);
    check("bp_reload_data", 0, 32'(out_data[0]), 32'h77);

    // Randomized traffic against the model, with one reset in the middle.
    do_reset();
    release_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (c == 1500) rst = 1'b1;
      if (c == 1502) rst = 1'b0;
      random_drive(20 + 30 * ((c / 400) % 3));
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
